// File: rtl/slide_timer_pkg.sv
// rtl/slide_timer_pkg.sv - shared state encoding and default widths for slide_timer
package slide_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/slide_timer_tick_sync.sv
// rtl/slide_timer_tick_sync.sv - synchronizer plus rising-edge detector producing one-cycle ticks
import slide_timer_pkg::*;

module tick_sync #(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic tick
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  // Edge taken only after the last sync flop, so a short glitch yields at most one tick.
  assign tick = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/slide_timer.sv
// rtl/slide_timer.sv - auto-advance slide timer with start/pause/stop/manual-advance control
import slide_timer_pkg::*;

module slide_timer #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             next_btn,
  input  logic [CNT_W-1:0] period,
  output logic             next_pulse,
  output logic [CNT_W-1:0] remaining,
  output logic [CNT_W-1:0] slide_cnt,
  output logic             running,
  output logic             paused
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state;
  logic   tick;
  logic   period_nz;

  tick_sync #(.STAGES(SYNC_STAGES)) u_tick_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (div_clk_in),
    .tick  (tick)
  );

  assign period_nz = (period != '0);

  // running/paused are assigned alongside every state change so they stay registered decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      next_pulse <= 1'b0;
      remaining  <= '0;
      slide_cnt  <= '0;
      running    <= 1'b0;
      paused     <= 1'b0;
    end else begin
      next_pulse <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        running   <= 1'b0;
        paused    <= 1'b0;
        remaining <= '0;
        slide_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (period_nz) begin
                state     <= RUN;
                running   <= 1'b1;
                paused    <= 1'b0;
                remaining <= period;
              end
            end else if (next_btn) begin
              next_pulse <= 1'b1;
              slide_cnt  <= slide_cnt + ONE;
            end
          end

          RUN: begin
            if (start) begin
              if (period_nz) remaining <= period;
            end else if (next_btn || (tick && !pause && remaining == ONE)) begin
              next_pulse <= 1'b1;
              slide_cnt  <= slide_cnt + ONE;
              remaining  <= period;
              // A zero period cannot be counted, so the slide show ends here.
              if (!period_nz) begin
                state   <= IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
              end
            end else if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
              paused  <= 1'b1;
            end else if (tick && remaining > ONE) begin
              remaining <= remaining - ONE;
            end
          end

          PAUSED: begin
            if (start || pause) begin
              state   <= RUN;
              running <= 1'b1;
              paused  <= 1'b0;
            end else if (next_btn) begin
              next_pulse <= 1'b1;
              slide_cnt  <= slide_cnt + ONE;
              remaining  <= period;
              if (!period_nz) begin
                state   <= IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
              end
            end
          end

          default: begin
            state     <= IDLE;
            running   <= 1'b0;
            paused    <= 1'b0;
            remaining <= '0;
          end
        endcase
      end
    end
  end

endmodule
